// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - fetch sequencer state encodings and default widths
//
// Purpose: shared definitions for instr_fetch.
//   fetch_state_t  : IDLE, REQ, WAIT, HOLD, FLUSH, REDIR
//   DEF_WIDTH      : default PC MSB index (PC is DEF_WIDTH+1 bits)
//   DEF_IWIDTH     : default instruction word width
//   resume_state() : where the sequencer goes once a fetch or redirect has finished
package instr_fetch_pkg;

  localparam int DEF_WIDTH  = 11;
  localparam int DEF_IWIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FLUSH = 3'd4,
    S_REDIR = 3'd5
  } fetch_state_t;

  // After a completed handshake or a redirect, keep fetching only while enabled.
  function automatic fetch_state_t resume_state(input logic en);
    return en ? S_REQ : S_IDLE;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch sequencer between ProgramCounter, memory and decode
//
// Purpose: reads instruction memory at pc, presents each word to decode over a
// valid/ready handshake, steers ProgramCounter with inc_pc/load_pc, and redirects
// on taken branches while discarding any read still in flight.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   en                 : run enable (a fetch in progress always completes)
//   pc                 : current ProgramCounter value
//   inc_pc, load_pc    : one-cycle pulses to ProgramCounter
//   pc_val             : branch target loaded on load_pc
//   mem_rd, mem_addr   : read request, held until mem_valid
//   mem_valid, mem_data: read response (one-cycle pulse)
//   instr, instr_pc    : fetched word and its address
//   instr_valid        : instr/instr_pc valid; instr_ready accepts
//   branch, branch_target : one-cycle redirect request
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int IWIDTH = DEF_IWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH:0]    pc,
  output logic              inc_pc,
  output logic              load_pc,
  output logic [WIDTH:0]    pc_val,
  output logic              mem_rd,
  output logic [WIDTH:0]    mem_addr,
  input  logic              mem_valid,
  input  logic [IWIDTH-1:0] mem_data,
  output logic [IWIDTH-1:0] instr,
  output logic [WIDTH:0]    instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch,
  input  logic [WIDTH:0]    branch_target
);

  fetch_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      inc_pc      <= 1'b0;
      load_pc     <= 1'b0;
      pc_val      <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      inc_pc  <= 1'b0;
      load_pc <= 1'b0;

      if (branch && (state != S_IDLE)) begin
        // Redirect wins over everything else; the data path only has to make
        // sure the read channel ends up idle before the next REQ.
        load_pc     <= 1'b1;
        pc_val      <= branch_target;
        instr_valid <= 1'b0;
        case (state)
          S_REQ: begin
            // The request goes out anyway, so it must be drained in FLUSH.
            mem_rd   <= 1'b1;
            mem_addr <= pc;
            state    <= S_FLUSH;
          end
          S_WAIT, S_FLUSH: begin
            // A response landing in the branch cycle is the stale one: drop it
            // and skip FLUSH, otherwise FLUSH would wait for a reply that never comes.
            if (mem_valid) begin
              mem_rd <= 1'b0;
              state  <= S_REDIR;
            end else begin
              state  <= S_FLUSH;
            end
          end
          default: state <= S_REDIR;  // HOLD, REDIR
        endcase
      end else begin
        case (state)
          S_IDLE: begin
            if (en) state <= S_REQ;
          end
          S_REQ: begin
            mem_rd   <= 1'b1;
            mem_addr <= pc;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (mem_valid) begin
              mem_rd      <= 1'b0;
              instr       <= mem_data;
              instr_pc    <= mem_addr;
              instr_valid <= 1'b1;
              inc_pc      <= 1'b1;
              state       <= S_HOLD;
            end
          end
          S_HOLD: begin
            // HOLD always lasts at least one cycle, which is what lets the
            // inc_pc pulse land before the next REQ samples pc.
            if (instr_valid && instr_ready) begin
              instr_valid <= 1'b0;
              state       <= resume_state(en);
            end
          end
          S_FLUSH: begin
            if (mem_valid) begin
              mem_rd <= 1'b0;
              state  <= S_REDIR;
            end
          end
          S_REDIR: begin
            // load_pc was high during this cycle, so pc is the target by REQ.
            state <= resume_state(en);
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
